// File: rtl/edge_event_arbiter.sv
// Round-robin serialiser of per-channel rising-edge events onto one valid/ready consumer; sticky drop flags.
// Latency: edge sampled at N -> pending after N -> out_valid after N+1. Backpressure: GRANT holds until out_ready.
// Optional saturating drop counter port drop_cnt enabled by `define EDGE_ARB_DROP_CNT_EN.
module edge_event_arbiter #(
    parameter int NCH = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] edge_in,
    input  logic [NCH-1:0] en_mask,
    output logic           out_valid,
    output logic [1:0]     out_id,
    input  logic           out_ready,
    output logic [NCH-1:0] ovf,
    input  logic           ovf_clr,
    output logic           busy
`ifdef EDGE_ARB_DROP_CNT_EN
    ,
    output logic [7:0]     drop_cnt
`endif
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t         state_q, state_d;
    logic [NCH-1:0] pending, pending_d;
    logic [NCH-1:0] ovf_d;
    logic [1:0]     rr_ptr, rr_d;
    logic           out_valid_d;
    logic [1:0]     out_id_d;

    logic           hs;
    logic [NCH-1:0] cap;
    logic [NCH-1:0] clr_vec;
    logic [NCH-1:0] drop;
    logic           found;
    logic [1:0]     pick_id;
    logic [1:0]     idx;

    // A channel being retired this cycle may re-arm without counting as a drop.
    always_comb begin
        hs          = out_valid & out_ready;
        cap         = edge_in & en_mask;
        clr_vec     = '0;
        if (hs) begin
            clr_vec[out_id] = 1'b1;
        end
        drop        = cap & pending & ~clr_vec;
        pending_d   = (pending & ~clr_vec) | cap;
        ovf_d       = (ovf_clr ? '0 : ovf) | drop;
    end

    // First pending channel searching upward from rr_ptr, wrapping mod 4.
    always_comb begin
        found   = 1'b0;
        pick_id = 2'd0;
        idx     = 2'd0;
        for (int k = 0; k < NCH; k++) begin
            idx = rr_ptr + 2'(k);
            if (!found && pending[idx]) begin
                found   = 1'b1;
                pick_id = idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid;
        out_id_d    = out_id;
        rr_d        = rr_ptr;
        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d     = GRANT;
                    out_valid_d = 1'b1;
                    out_id_d    = pick_id;
                end
            end
            GRANT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    rr_d        = out_id + 2'd1;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending   <= '0;
            rr_ptr    <= 2'd0;
            out_valid <= 1'b0;
            out_id    <= 2'd0;
            ovf       <= '0;
        end else begin
            state_q   <= state_d;
            pending   <= pending_d;
            rr_ptr    <= rr_d;
            out_valid <= out_valid_d;
            out_id    <= out_id_d;
            ovf       <= ovf_d;
        end
    end

    assign busy = (|pending) | out_valid;

`ifdef EDGE_ARB_DROP_CNT_EN
    // One count per cycle with any drop; a drop coincident with clear leaves a count of 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'd0;
        end else if (ovf_clr) begin
            drop_cnt <= (|drop) ? 8'd1 : 8'd0;
        end else if ((|drop) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed table-driven bench for edge_event_arbiter plus hand-written drop/saturation/order sequences.
module tb_edge_event_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] edge_in;
    logic [3:0] en_mask;
    logic       out_valid;
    logic [1:0] out_id;
    logic       out_ready;
    logic [3:0] ovf;
    logic       ovf_clr;
    logic       busy;
`ifdef EDGE_ARB_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    edge_event_arbiter #(.NCH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .edge_in   (edge_in),
        .en_mask   (en_mask),
        .out_valid (out_valid),
        .out_id    (out_id),
        .out_ready (out_ready),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
`ifdef EDGE_ARB_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] edge_in;
        logic [3:0] en_mask;
        logic       rdy;
        logic       clr;
        logic       v;
        logic [1:0] id;
        logic [3:0] ovf;
        logic       busy;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[$];
    int   total = 0;
    int   bad   = 0;

    task automatic add(input logic r, input logic [3:0] e, input logic [3:0] m, input logic rd,
                       input logic c, input logic v, input logic [1:0] id, input logic [3:0] o,
                       input logic b, input logic [7:0] n);
        vec_t t;
        t.rst = r; t.edge_in = e; t.en_mask = m; t.rdy = rd; t.clr = c;
        t.v = v; t.id = id; t.ovf = o; t.busy = b; t.cnt = n;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic rd, input logic c);
        rst = r; edge_in = e; out_ready = rd; ovf_clr = c; en_mask = 4'hF;
    endtask

    int grants;
    int cycles;

    initial begin
        rst = 1'b1; edge_in = 4'h0; en_mask = 4'hF; out_ready = 1'b1; ovf_clr = 1'b0;

        //   rst edge   mask   rdy clr | v id ovf    busy cnt
        // two-channel pulse, reset-time pulse ignored
        add(1, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 0, 0);
        add(1, 4'hF, 4'hF, 1, 0,   0, 0, 4'h0, 0, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 0, 0);
        add(0, 4'h5, 4'hF, 1, 0,   0, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 2, 4'h0, 0, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 2, 4'h0, 0, 0);
        // round-robin order with backpressure, then wrap 3 -> 0
        add(1, 4'h0, 4'hF, 0, 0,   0, 0, 4'h0, 0, 0);
        add(0, 4'hF, 4'hF, 0, 0,   0, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0,   1, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0,   1, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 3, 4'h0, 0, 0);
        add(0, 4'hF, 4'hF, 1, 0,   0, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 3, 4'h0, 0, 0);
        // drop on channel 3, clear, clear coincident with new drop
        add(0, 4'h8, 4'hF, 0, 0,   0, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0,   1, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0,   1, 3, 4'h0, 1, 0);
        add(0, 4'h8, 4'hF, 0, 0,   1, 3, 4'h8, 1, 1);
        add(0, 4'h0, 4'hF, 0, 0,   1, 3, 4'h8, 1, 1);
        add(0, 4'h0, 4'hF, 0, 1,   1, 3, 4'h0, 1, 0);
        add(0, 4'h8, 4'hF, 0, 1,   1, 3, 4'h8, 1, 1);
        add(0, 4'h0, 4'hF, 0, 1,   1, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 3, 4'h0, 0, 0);
        // re-arm in the handshake cycle is not a drop
        add(0, 4'h4, 4'hF, 1, 0,   0, 3, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 2, 4'h0, 1, 0);
        add(0, 4'h4, 4'hF, 1, 0,   0, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   1, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 2, 4'h0, 0, 0);
        // capture mask
        add(0, 4'h3, 4'hE, 1, 0,   0, 2, 4'h0, 1, 0);
        add(0, 4'h0, 4'hE, 1, 0,   1, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hE, 1, 0,   0, 1, 4'h0, 0, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 1, 4'h0, 0, 0);
        // reset while presenting with pending=1010
        add(0, 4'hA, 4'hF, 0, 0,   0, 1, 4'h0, 1, 0);
        add(0, 4'h0, 4'hF, 0, 0,   1, 3, 4'h0, 1, 0);
        add(1, 4'h0, 4'hF, 0, 0,   0, 0, 4'h0, 0, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 0, 0);
        add(0, 4'h0, 4'hF, 1, 0,   0, 0, 4'h0, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            rst = vecs[i].rst; edge_in = vecs[i].edge_in; en_mask = vecs[i].en_mask;
            out_ready = vecs[i].rdy; ovf_clr = vecs[i].clr;
            step();
            check($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(vecs[i].v));
            check($sformatf("row%0d out_id", i),    32'(out_id),    32'(vecs[i].id));
            check($sformatf("row%0d ovf", i),       32'(ovf),       32'(vecs[i].ovf));
            check($sformatf("row%0d busy", i),      32'(busy),      32'(vecs[i].busy));
`ifdef EDGE_ARB_DROP_CNT_EN
            check($sformatf("row%0d drop_cnt", i),  32'(drop_cnt),  32'(vecs[i].cnt));
`endif
        end

        // multi-channel drops in one cycle, then drain in order 0,1,2,3
        drive(1, 4'h0, 0, 0); step();
        drive(0, 4'hF, 0, 0); step();
        drive(0, 4'h0, 0, 0); step();
        drive(0, 4'h6, 0, 0); step();
        check("multi drop ovf", 32'(ovf), 32'h6);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("multi drop cnt", 32'(drop_cnt), 32'd1);
`endif
        drive(0, 4'h9, 0, 0); step();
        check("multi drop ovf2", 32'(ovf), 32'hF);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("multi drop cnt2", 32'(drop_cnt), 32'd2);
`endif
        drive(0, 4'h0, 1, 0);
        grants = 0;
        cycles = 0;
        while (busy && cycles < 20) begin
            if (out_valid) begin
                check($sformatf("drain id%0d", grants), 32'(out_id), 32'(grants));
                grants++;
            end
            step();
            cycles++;
        end
        check("drain done in budget", 32'(busy), 32'd0);
        check("drain grant count", 32'(grants), 32'd4);
        check("ovf sticky after drain", 32'(ovf), 32'hF);

        // 300 drops on channel 0 with backpressure
        drive(1, 4'h0, 0, 0); step();
        for (int i = 0; i < 301; i++) begin
            drive(0, 4'h1, 0, 0); step();
        end
        drive(0, 4'h0, 0, 0); step();
        check("sat ovf", 32'(ovf), 32'h1);
        check("sat held valid", 32'(out_valid), 32'd1);
        check("sat held id", 32'(out_id), 32'd0);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("sat drop_cnt", 32'(drop_cnt), 32'd255);
`endif
        drive(0, 4'h0, 0, 1); step();
        check("clr ovf", 32'(ovf), 32'h0);
`ifdef EDGE_ARB_DROP_CNT_EN
        check("clr drop_cnt", 32'(drop_cnt), 32'd0);
`endif
        drive(0, 4'h0, 1, 0); step();
        check("final handshake valid", 32'(out_valid), 32'd0);
        check("final busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
